// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial W-bit adder sequencer around one full-adder cell
// Optional subtract mode and sub port are enabled by defining SERIAL_SUB_EN.
module serial_add_ctrl #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
`ifdef SERIAL_SUB_EN
   ,
   input  logic         sub
`endif
);

   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]     a_sr, b_sr, s_sr;
   logic             c;
   logic [CNT_W-1:0] cnt;

   logic             load, shift, finish;
   logic             fa_sum, fa_co;
   logic [W-1:0]     b_load;
   logic             c_load;

   // Subtraction is a + ~b + 1, so only the captured B and carry differ.
`ifdef SERIAL_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   assign fa_sum = a_sr[0] ^ b_sr[0] ^ c;
   assign fa_co  = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy  = 1'b1;
            shift = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Result bits enter at the MSB so after W shifts s_sr holds the sum in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr <= '0;
         b_sr <= '0;
         s_sr <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            a_sr <= a;
            b_sr <= b_load;
            c    <= c_load;
            cnt  <= '0;
         end else if (shift) begin
            a_sr <= {1'b0, a_sr[W-1:1]};
            b_sr <= {1'b0, b_sr[W-1:1]};
            s_sr <= {fa_sum, s_sr[W-1:1]};
            c    <= fa_co;
            cnt  <= cnt + CNT_W'(1);
         end
         if (finish) begin
            sum  <= s_sr;
            cout <= c;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

   localparam int W = 4;
   localparam int LAT = W + 2;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         sub;
   logic         ready, busy, done, cout;
   logic [W-1:0] sum;

   int total = 0;
   int bad   = 0;

   serial_add_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_SUB_EN
      ,
      .sub   (sub)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic s);
      logic [W-1:0] d;
      if (s) begin
         d = x - y;
         return {(x >= y), d};
      end
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   // Launches one operation from a negedge with ready=1; returns at the done sample.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic is, output int lat, output int busy_n, output int held_bad);
      logic [W-1:0] prev_sum;
      logic         prev_cout;
      prev_sum  = sum;
      prev_cout = cout;
      a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 1; busy_n = 0; held_bad = 0;
      while (!done && lat < 50) begin
         if (busy) busy_n++;
         if (sum !== prev_sum || cout !== prev_cout) held_bad = 1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if ({ready, busy, done} !== 3'b100) begin bad++;
         $display("FAIL reset_flags got=%b exp=100", {ready, busy, done}); end
      total++; if ({cout, sum} !== '0) begin bad++;
         $display("FAIL reset_result got=%0h exp=0", {cout, sum}); end
   endtask

   task automatic test_directed();
      int lat, bn, hb;
      run_op(4'd7, 4'd9, 1'b0, 1'b0, lat, bn, hb);
      total++; if (lat !== LAT) begin bad++; $display("FAIL dir_latency got=%0d exp=%0d", lat, LAT); end
      total++; if (bn !== W) begin bad++; $display("FAIL dir_busy_cycles got=%0d exp=%0d", bn, W); end
      total++; if ({cout, sum} !== 5'h10) begin bad++;
         $display("FAIL dir_7p9 got=%0h exp=10", {cout, sum}); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir_done_pulse got=%b exp=0", done); end
      run_op(4'd3, 4'd2, 1'b1, 1'b0, lat, bn, hb);
      total++; if (hb !== 0) begin bad++; $display("FAIL dir_hold got=%0d exp=0", hb); end
      total++; if ({cout, sum} !== 5'h06) begin bad++;
         $display("FAIL dir_3p2p1 got=%0h exp=06", {cout, sum}); end
      run_op(4'hF, 4'hF, 1'b1, 1'b0, lat, bn, hb);
      total++; if ({cout, sum} !== 5'h1F) begin bad++;
         $display("FAIL dir_FpFp1 got=%0h exp=1f", {cout, sum}); end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int dones;
      logic [W-1:0] got;
      dones = 0; got = '0;
      a = 4'd1; b = 4'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 3 * LAT; i++) begin
         if (i == 2) begin start = 1'b1; a = 4'hF; end
         else start = 1'b0;
         @(negedge clk);
         if (done) begin dones++; got = sum; end
      end
      total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
      total++; if (got !== 4'd2) begin bad++; $display("FAIL ignore_sum got=%0h exp=2", got); end
   endtask

   task automatic test_back_to_back();
      int idx[$];
      a = 4'd1; b = 4'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
      for (int i = 0; i < 60 && idx.size() < 3; i++) begin
         @(negedge clk);
         if (done) begin
            idx.push_back(i);
            total++; if ({cout, sum} !== 5'h02) begin bad++;
               $display("FAIL b2b_sum got=%0h exp=02", {cout, sum}); end
         end
      end
      start = 1'b0;
      total++; if (idx.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", idx.size()); end
      else begin
         total++; if (idx[1] - idx[0] !== LAT || idx[2] - idx[1] !== LAT) begin bad++;
            $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", idx[1] - idx[0], idx[2] - idx[1], LAT); end
      end
      repeat (2 * LAT) @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", ready); end
   endtask

   task automatic test_random(input logic with_sub, input int n);
      int lat, bn, hb;
      logic [W-1:0] ra, rb;
      logic rc, rs;
      logic [W:0] exp;
      for (int i = 0; i < n; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         rs = with_sub ? 1'($urandom) : 1'b0;
         exp = model(ra, rb, rc, rs);
         run_op(ra, rb, rc, rs, lat, bn, hb);
         total++; if ({cout, sum} !== exp || lat !== LAT || hb !== 0) begin bad++;
            $display("FAIL rand_op a=%0h b=%0h c=%0b s=%0b got=%0h exp=%0h lat=%0d held_bad=%0d",
                     ra, rb, rc, rs, {cout, sum}, exp, lat, hb); end
         @(negedge clk);
         total++; if (done !== 1'b0) begin bad++; $display("FAIL rand_done_pulse got=%b exp=0", done); end
      end
   endtask

`ifdef SERIAL_SUB_EN
   task automatic test_sub();
      int lat, bn, hb;
      run_op(4'd5, 4'd7, 1'b0, 1'b1, lat, bn, hb);
      total++; if ({cout, sum} !== 5'h0E) begin bad++;
         $display("FAIL sub_5m7 got=%0h exp=0e", {cout, sum}); end
      @(negedge clk);
      run_op(4'd7, 4'd5, 1'b0, 1'b1, lat, bn, hb);
      total++; if ({cout, sum} !== 5'h12) begin bad++;
         $display("FAIL sub_7m5 got=%0h exp=12", {cout, sum}); end
      @(negedge clk);
      test_random(1'b1, 20);
   endtask
`endif

   task automatic test_reset_mid_shift();
      int lat, bn, hb;
      run_op(4'd3, 4'd2, 1'b1, 1'b0, lat, bn, hb);
      @(negedge clk);
      a = 4'd9; b = 4'd4; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if ({ready, busy, done} !== 3'b100) begin bad++;
         $display("FAIL midrst_flags got=%b exp=100", {ready, busy, done}); end
      total++; if ({cout, sum} !== '0) begin bad++;
         $display("FAIL midrst_result got=%0h exp=0", {cout, sum}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * LAT) @(negedge clk);
      total++; if ({ready, busy, cout, sum} !== {2'b10, 5'h00}) begin bad++;
         $display("FAIL midrst_discard got=%0h exp=40", {ready, busy, cout, sum}); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_random(1'b0, 40);
`ifdef SERIAL_SUB_EN
      test_sub();
`endif
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
